// File: rtl/bcd_updown_counter_scan.sv
// Multi-digit modulo-N BCD up/down counter stepped by a debounced
// button, with range-checked load and a multiplexed 7-segment scan.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   btn       raw push-button, idle high, pressed low
//   en        1 = accept steps
//   dir       1 = count up, 0 = count down
//   load_n    synchronous active-low load strobe
//   load_val  BCD load value, digit 0 in [3:0]
//   count     current BCD count
//   btn_pulse one-cycle accepted-press pulse
//   carry     one-cycle wrap pulse
//   load_err  one-cycle rejected-load pulse
//   dig_sel   one-hot active-low digit enable
//   seg_led   segments of the selected digit, [6:0] = g..a
module bcd_updown_counter_scan #(
  parameter int DIGITS     = 2,
  parameter int MODULUS    = 60,
  parameter int DEB_CYCLES = 240000,
  parameter int SCAN_DIV   = 12000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  input  logic                en,
  input  logic                dir,
  input  logic                load_n,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                btn_pulse,
  output logic                carry,
  output logic                load_err,
  output logic [DIGITS-1:0]   dig_sel,
  output logic [8:0]          seg_led
);

  localparam int W  = 4 * DIGITS;
  localparam int DW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST =
    SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DIGITS - 1);

  function automatic logic [W-1:0] to_bcd(
    input int v
  );
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // With every digit <= 9, packed BCD orders like
  // binary, so range checks are plain compares.
  localparam logic [W-1:0] MAX_BCD =
    to_bcd(MODULUS - 1);

  function automatic logic all_bcd(
    input logic [W-1:0] v
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_inc(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Debounce
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_dly_q;
  logic [DW-1:0] deb_cnt_q;
  logic          pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      deb_cnt_q    <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_dly_q & ~stable_q;
      if (sync2_q == stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        stable_q  <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end
  end

  // Counter
  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;
  logic         step;

  assign step = load_n & pulse_q & en;

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      !load_n: begin
        if (all_bcd(load_val) &&
            load_val <= MAX_BCD) begin
          count_d = load_val;
        end else begin
          count_d = '0;
          err_d   = 1'b1;
        end
      end
      step && dir: begin
        if (count_q == MAX_BCD) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end
      step && !dir: begin
        if (count_q == '0) begin
          count_d = MAX_BCD;
          carry_d = 1'b1;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // Scan
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    cur_dig;
  logic [8:0]    seg_q, seg_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      if (idx_q == IDX_LAST) idx_d = '0;
      else idx_d = idx_q + IW'(1);
    end
  end

  // Segments come from next-state index and count so
  // they line up with dig_sel and the new count.
  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_dig = count_d[4*i +: 4];
      end
    end
    seg_d = {2'b00, seg7(cur_dig)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 9'h03f;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    dig_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) dig_sel[i] = 1'b0;
    end
  end

  assign count     = count_q;
  assign btn_pulse = pulse_q;
  assign carry     = carry_q;
  assign load_err  = err_q;
  assign seg_led   = seg_q;

endmodule

// File: tb/tb_bcd_updown_counter_scan.sv
// Directed bench for bcd_updown_counter_scan with a count
// scoreboard and immediate-assertion checks.
module tb_bcd_updown_counter_scan;

  logic       clk = 1'b0;
  logic       rst, btn, en, dir, load_n;
  logic [7:0] load_val, count;
  logic       btn_pulse, carry, load_err;
  logic [1:0] dig_sel;
  logic [8:0] seg_led;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  bcd_updown_counter_scan #(
    .DIGITS(2), .MODULUS(60),
    .DEB_CYCLES(4), .SCAN_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .en(en), .dir(dir), .load_n(load_n),
    .load_val(load_val), .count(count),
    .btn_pulse(btn_pulse), .carry(carry),
    .load_err(load_err), .dig_sel(dig_sel),
    .seg_led(seg_led)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [7:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    e = sb_q.pop_front();
    chk(tag, 32'(count), 32'(e));
  endtask

  task automatic do_load(input logic [7:0] v,
                         input logic [7:0] exp,
                         input logic exp_err,
                         input string tag);
    load_n = 1'b0;
    load_val = v;
    sb_push(exp);
    step();
    sb_check(tag);
    chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
    load_n = 1'b1;
    sb_push(exp);
    step();
    sb_check({tag, "_hold"});
    chk({tag, "_err1"}, 32'(load_err), 32'd0);
  endtask

  task automatic press(input logic [7:0] exp,
                       input logic exp_c,
                       input string tag);
    bit seen;
    seen = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (btn_pulse) seen = 1'b1;
    end
    chk({tag, "_pulse"}, 32'(seen), 32'd1);
    sb_push(exp);
    step();
    sb_check(tag);
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    btn = 1'b1;
    step();
    chk({tag, "_carry1"}, 32'(carry), 32'd0);
    repeat (8) step();
  endtask

  initial begin
    bit seen;
    int idx;

    rst = 1'b0; btn = 1'b1; en = 1'b1;
    dir = 1'b1; load_n = 1'b1; load_val = 8'h00;
    repeat (2) step();
    rst = 1'b1;
    sb_push(8'h00);
    sb_check("rst_count");
    chk("rst_dig", 32'(dig_sel), 32'h2);
    chk("rst_seg", 32'(seg_led), 32'h03f);
    chk("rst_pulse", 32'(btn_pulse), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    // async reset mid-count
    do_load(8'h37, 8'h37, 1'b0, "ld37");
    #2 rst = 1'b0;
    #1;
    sb_push(8'h00);
    sb_check("arst_count");
    chk("arst_dig", 32'(dig_sel), 32'h2);
    chk("arst_seg", 32'(seg_led), 32'h03f);
    #1 rst = 1'b1;
    step();

    // bounce then hold: one pulse, 7 edges after fall
    btn = 1'b0;
    repeat (3) step();
    btn = 1'b1;
    repeat (2) step();
    btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("deb_pulse%0d", k),
          32'(btn_pulse), 32'(k == 6));
      sb_push((k >= 7) ? 8'h01 : 8'h00);
      sb_check($sformatf("deb_count%0d", k));
    end
    btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("rel_pulse%0d", k),
          32'(btn_pulse), 32'd0);
    end
    sb_push(8'h01);
    sb_check("rel_count");

    // up count and wrap
    dir = 1'b1;
    do_load(8'h58, 8'h58, 1'b0, "ld58");
    press(8'h59, 1'b0, "up59");
    press(8'h00, 1'b1, "upwrap");
    en = 1'b0;
    press(8'h00, 1'b0, "en0");
    en = 1'b1;

    // down count and wrap
    dir = 1'b0;
    do_load(8'h10, 8'h10, 1'b0, "ld10");
    press(8'h09, 1'b0, "dn09");
    do_load(8'h00, 8'h00, 1'b0, "ld00");
    press(8'h59, 1'b1, "dnwrap");

    // loads
    dir = 1'b1;
    do_load(8'h47, 8'h47, 1'b0, "ld47");
    do_load(8'h3a, 8'h00, 1'b1, "ld3a");
    do_load(8'h60, 8'h00, 1'b1, "ld60");

    // load wins over a same-cycle step
    seen = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (btn_pulse) seen = 1'b1;
    end
    chk("ldpr_pulse", 32'(seen), 32'd1);
    load_n = 1'b0;
    load_val = 8'h12;
    sb_push(8'h12);
    step();
    sb_check("ldpr_count");
    chk("ldpr_carry", 32'(carry), 32'd0);
    chk("ldpr_err", 32'(load_err), 32'd0);
    load_n = 1'b1;
    sb_push(8'h12);
    step();
    sb_check("ldpr_hold");
    btn = 1'b1;
    repeat (8) step();

    // scan
    do_load(8'h47, 8'h47, 1'b0, "ld47s");
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dig_sel == 2'b10) seen = 1'b1;
    end
    chk("scan_find10", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (dig_sel == 2'b01) seen = 1'b1;
      else step();
    end
    chk("scan_find01", 32'(seen), 32'd1);
    for (int k = 0; k < 12; k++) begin
      idx = (1 + k / 3) % 2;
      chk($sformatf("scan_dig%0d", k),
          32'(dig_sel),
          (idx == 1) ? 32'h1 : 32'h2);
      chk($sformatf("scan_seg%0d", k),
          32'(seg_led),
          (idx == 1) ? 32'h066 : 32'h007);
      step();
    end
    sb_push(8'h47);
    sb_check("scan_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
